// File: rtl/kmap_scanner.sv
// kmap_scanner: sequential truth-table extractor and checker for small
// combinational functions (2..5 inputs). Drives every input vector on stim,
// waits SETTLE_CYC cycles, samples f_in, builds the truth table and counts
// disagreements against an expected minterm mask latched at start.
//
// Optional build macro KMAP_SCAN_GRAY_EN: when defined, the sweep visits the
// vectors in reflected Gray-code order so only one input toggles per step.
// truth, expected and first_err_idx stay indexed by the binary stim value.
// When undefined, the sweep is plain binary order 0..2**N_IN-1.
module kmap_scanner #(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 err_valid,
  output logic [N_IN-1:0]      first_err_idx
);

  localparam int W = 2**N_IN;

  // Settle counter compares against SETTLE_CYC-1 so the vector is held for
  // exactly SETTLE_CYC cycles before the SAMPLE cycle.
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] K_LAST      = '1;
  localparam logic [N_IN-1:0] K_ONE       = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE     = {{N_IN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state;
  logic [N_IN-1:0] sweep_k;
  logic [N_IN-1:0] k_next;
  logic [N_IN-1:0] stim_next;
  logic [3:0]      settle_cnt;
  logic [W-1:0]    exp_mask;

  // Next sweep position and the stim vector it maps to; the sweep ends when
  // the position counter reaches all ones in either ordering.
  always_comb begin
    k_next = sweep_k + K_ONE;
`ifdef KMAP_SCAN_GRAY_EN
    stim_next = k_next ^ (k_next >> 1);
`else
    stim_next = k_next;
`endif
  end

  // Scan controller: sequences settle/sample per vector and accumulates results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sweep_k       <= '0;
      stim          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      truth         <= '0;
      mismatch_cnt  <= '0;
      err_valid     <= 1'b0;
      first_err_idx <= '0;
      settle_cnt    <= '0;
      exp_mask      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_mask      <= expected;
            truth         <= '0;
            mismatch_cnt  <= '0;
            err_valid     <= 1'b0;
            first_err_idx <= '0;
            sweep_k       <= '0;
            stim          <= '0;
            settle_cnt    <= '0;
            busy          <= 1'b1;
            state         <= SETTLE;
          end
        end

        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          truth[stim] <= f_in;
          if (f_in != exp_mask[stim]) begin
            mismatch_cnt <= mismatch_cnt + CNT_ONE;
            if (!err_valid) begin
              err_valid     <= 1'b1;
              first_err_idx <= stim;
            end
          end
          if (sweep_k == K_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sweep_k    <= k_next;
            stim       <= stim_next;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end

        DONE: begin
          done    <= 1'b0;
          stim    <= '0;
          sweep_k <= '0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmap_scanner.sv
// tb_kmap_scanner: scoreboard bench for kmap_scanner with N_IN=4, SETTLE_CYC=1.
// A K1-style function (f = ~b&c | ~a&b&d | a&~c&~d) or a tied constant is
// attached to stim. Each requested scan pushes its hand-computed result into
// a queue; a monitor pops and compares whenever done pulses.
module tb_kmap_scanner;

  localparam int N_IN       = 4;
  localparam int SETTLE_CYC = 1;
  localparam int SCAN_CYC   = (2**N_IN) * (SETTLE_CYC + 1);
`ifdef KMAP_SCAN_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] truth;
    logic [4:0]  cnt;
    logic        err;
    logic [3:0]  first;
  } result_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] expected;
  logic        f_in;
  logic [3:0]  stim;
  logic        busy;
  logic        done;
  logic [15:0] truth;
  logic [4:0]  mismatch_cnt;
  logic        err_valid;
  logic [3:0]  first_err_idx;

  int      checks;
  int      failures;
  int      f_mode;
  result_t sb[$];

  int          busy_run;
  int          pos;
  logic [3:0]  last_stim;

  kmap_scanner #(
    .N_IN       (N_IN),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .expected      (expected),
    .f_in          (f_in),
    .stim          (stim),
    .busy          (busy),
    .done          (done),
    .truth         (truth),
    .mismatch_cnt  (mismatch_cnt),
    .err_valid     (err_valid),
    .first_err_idx (first_err_idx)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Function under test: K1 (mode 0), tied 0 (mode 1), tied 1 (mode 2).
  always_comb begin
    f_in = 1'b0;
    case (f_mode)
      0: f_in = (~stim[2] & stim[1]) | (~stim[3] & stim[2] & stim[0]) |
                (stim[3] & ~stim[1] & ~stim[0]);
      2: f_in = 1'b1;
      default: f_in = 1'b0;
    endcase
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] order_at(input int k);
    logic [3:0] kk;
    kk = 4'(k);
    if (GRAY) return kk ^ (kk >> 1);
    return kk;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] want);
    checks++;
    if (actual !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, want, $time);
    end
  endtask

  // Monitor: checks sweep order while busy and pops the scoreboard on done.
  always @(negedge clk) begin
    result_t r;
    if (rst) begin
      busy_run = 0;
      pos      = 0;
    end else begin
      if (busy) begin
        busy_run++;
        if (busy_run == 1 || stim != last_stim) begin
          checkOutput("stim_order", 32'(stim), 32'(order_at(pos)));
          pos++;
        end
        last_stim = stim;
      end
      if (done) begin
        checkOutput("done_has_request", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          r = sb.pop_front();
          checkOutput("truth", 32'(truth), 32'(r.truth));
          checkOutput("mismatch_cnt", 32'(mismatch_cnt), 32'(r.cnt));
          checkOutput("err_valid", 32'(err_valid), 32'(r.err));
          checkOutput("first_err_idx", 32'(first_err_idx), 32'(r.first));
          checkOutput("busy_cycles", 32'(busy_run), 32'(SCAN_CYC));
          checkOutput("vectors_visited", 32'(pos), 32'd16);
          checkOutput("busy_low_at_done", 32'(busy), 32'd0);
        end
        busy_run = 0;
        pos      = 0;
      end
    end
  end

  // One scan request. abort_at>0 asserts rst that many edges into the scan.
  task automatic applyStimulus(input logic [15:0] mask, input int fmode,
                               input result_t want, input int repulse_at,
                               input int abort_at);
    bit got_done;
    bit aborted;
    got_done = 1'b0;
    aborted  = 1'b0;
    @(posedge clk); #1;
    f_mode   = fmode;
    expected = mask;
    start    = 1'b1;
    if (abort_at == 0) sb.push_back(want);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == repulse_at);
      if (cyc == 1) expected = ~mask;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (abort_at != 0 && cyc == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1'b1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_stim", 32'(stim), 32'd0);
        checkOutput("abort_truth", 32'(truth), 32'd0);
        checkOutput("abort_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
        checkOutput("abort_err_valid", 32'(err_valid), 32'd0);
        break;
      end
    end
    if (aborted) begin
      repeat (40) @(posedge clk);
    end else begin
      checkOutput("done_seen", 32'(got_done), 32'd1);
      @(posedge clk); #1;
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("stim_back_to_zero", 32'(stim), 32'd0);
      checkOutput("idle_busy_low", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_holds_truth", 32'(truth), 32'(want.truth));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    f_mode   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    expected = 16'h0000;
    busy_run = 0;
    pos      = 0;
    last_stim = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stim", 32'(stim), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_truth", 32'(truth), 32'd0);
    checkOutput("reset_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    checkOutput("reset_err_valid", 32'(err_valid), 32'd0);
    checkOutput("reset_first_err_idx", 32'(first_err_idx), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // K1 with its correct mask: clean pass.
    applyStimulus(16'h1DAC, 0, '{16'h1DAC, 5'd0, 1'b0, 4'd0}, 0, 0);
    // K1 against a mask wrong in bit 0 only.
    applyStimulus(16'h1DAD, 0, '{16'h1DAC, 5'd1, 1'b1, 4'd0}, 0, 0);
    // Tied 0 against all ones: every index mismatches, count reaches 16.
    applyStimulus(16'hFFFF, 1, '{16'h0000, 5'd16, 1'b1, 4'd0}, 0, 0);
    // Tied 0 against bits 8..11: first visited mismatch depends on sweep order.
    applyStimulus(16'h0F00, 1, '{16'h0000, 5'd4, 1'b1, (GRAY ? 4'd10 : 4'd8)}, 0, 0);
    // Tied 1 against a mask missing only the top index.
    applyStimulus(16'h7FFF, 2, '{16'hFFFF, 5'd1, 1'b1, 4'd15}, 0, 0);
    // K1 aborted by reset ten edges in, then a fresh full scan.
    applyStimulus(16'h1DAC, 0, '{16'h1DAC, 5'd0, 1'b0, 4'd0}, 0, 10);
    applyStimulus(16'h1DAC, 0, '{16'h1DAC, 5'd0, 1'b0, 4'd0}, 0, 0);
    // Start re-pulsed mid-scan must be ignored.
    applyStimulus(16'h1DAD, 0, '{16'h1DAC, 5'd1, 1'b1, 4'd0}, 5, 0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
